mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

Parametrised N-port round-robin arbiter for the single-port image SRAM. It replaces the two-way busy-selected mux between the JTAG front-end and the interpolation control unit with a registered arbiter. The arbiter supports any number of requesters, per-port exclusive lock for bursts, and read-return routing that tracks the memory's read latency. It sits between the requesters (`connect`, `control_unit`, future DMA/readback engines) and `mem_sram_simple`.

## Interface
- `NUM_PORTS`, 2: number of requesters, ≥2.
- `ADDR_BITS`, 16: address width, both per port and to memory.
- `DATA_BITS`, 8: data width.
- `RD_LATENCY`, 1: memory cycles from registered address to valid `mem_rdata`, ≥1.
- `clk` in 1: single clock; all logic on rising edge.
- `aclr` in 1: asynchronous, active-high reset.
- `req` in NUM_PORTS: per-port access request, held with its fields until accepted.
- `we` in NUM_PORTS: 1 = write, 0 = read.
- `addr` in NUM_PORTS*ADDR_BITS: port i at bits [i*ADDR_BITS +: ADDR_BITS].
- `wdata` in NUM_PORTS*DATA_BITS: same packing.
- `lock` in NUM_PORTS: port requests exclusive ownership.
- `gnt` out NUM_PORTS: combinational one-hot accept; `req[i]&gnt[i]` means the access transfers this cycle.
- `rvalid` out NUM_PORTS: one-hot read-data-valid pulse.
- `rdata` out DATA_BITS: read data, broadcast; qualified by `rvalid`.
- `owner` out max(1,$clog2(NUM_PORTS)): registered index of last granted port.
- `locked` out 1: a port currently holds the lock.
- `mem_en` out 1: registered; memory command valid.
- `mem_we` out 1: registered write enable (0 when `mem_en`=0).
- `mem_addr` out ADDR_BITS: registered address.
- `mem_wdata` out DATA_BITS: registered write data.
- `mem_rdata` in DATA_BITS: memory read data.

## Operation
- Round-robin: priority starts at `owner+1` and wraps modulo NUM_PORTS. The lowest-distance requesting port wins. At most one `gnt` bit is high per cycle, and it is never high without the matching `req`.
- On accept of port i: `mem_en`=1, `mem_we`=`we[i]`, `mem_addr`/`mem_wdata` from port i are registered, and `owner`←i.
- No accept: `mem_en`=0, `mem_we`=0, `mem_addr`/`mem_wdata` hold their previous values, `owner` holds.
- Lock state machine, states UNLOCKED and LOCKED(i):
  - UNLOCKED→LOCKED(i) when port i is accepted with `lock[i]`=1.
  - In LOCKED(i), only port i is eligible; all other requests wait with `gnt`=0.
  - LOCKED(i)→UNLOCKED on any cycle where `lock[i]`=0, evaluated combinationally, so arbitration that same cycle is already open to all ports.
  - `locked`=1 exactly in LOCKED.
- Read return: a RD_LATENCY+1 stage shift register carries {read-valid, port index}, advanced every cycle. It covers the address-register stage plus RD_LATENCY.
  - `rvalid[p]` is asserted when the tail stage is valid with index p. `rdata`=`mem_rdata` combinationally.
  - Writes enter the pipeline as invalid and never produce `rvalid`.
- Back-to-back accepts are allowed every cycle, from the same or different ports. Reads from different ports return in issue order.

## Timing
- Accept in cycle N: `mem_*` are valid in N+1, and `rvalid`/`rdata` are valid in N+1+RD_LATENCY.
- `gnt` depends combinationally on `req`, `lock`, and state. There is no combinational path from `gnt` back to `req`.
- Throughput is one access per clock. Worst-case wait for an unlocked requester is NUM_PORTS−1 grants.
- Reset values: `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `owner`=NUM_PORTS−1 (port 0 has first priority), lock state UNLOCKED, `locked`=0, pipeline cleared so `rvalid`=0.
- Reset mid-operation: in-flight reads are discarded with no `rvalid`, and a pending lock is dropped. Requesters reissue.
- `req` dropped before accept: the request is withdrawn with no side effect.

## Test plan
- Reset, NUM_PORTS=2, RD_LATENCY=1: assert `aclr` async mid-cycle → all outputs reach reset values immediately. Then `req`=2'b11 → port 0 is granted first.
- Continuous `req`=4'b1111 with NUM_PORTS=4 → grant order 0,1,2,3,0; `mem_en`=1 every cycle; each port gets exactly 1 grant in 4.
- Port 1 writes 0xA5 to addr 0x0010, then port 0 reads 0x0010 (RD_LATENCY=1): read accepted in cycle N → `rvalid`=2'b01 and `rdata`=0xA5 in N+2; `rvalid[1]` never asserts.
- Port 1 accepted with `lock[1]`=1 for 5 accesses while port 0 requests → `gnt[0]`=0 throughout. Drop `lock[1]` → `gnt[0]` in that same cycle.
- RD_LATENCY=3 interleaved reads from ports 2,0,2 in consecutive cycles → `rvalid` one-hots 4,1,4 in cycles N+4..N+6.
- Read in flight when `aclr` pulses → no `rvalid` after reset; `mem_en`=0 until the next accept.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter for N requesters sharing the single-port image SRAM.
// Supports per-port burst lock and routes read data back to the issuing port.
module mem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 8,
    parameter int RD_LATENCY = 1,
    localparam int IDX_BITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk_i,
    input  logic                           aclr_i,
    input  logic [NUM_PORTS-1:0]           req_i,
    input  logic [NUM_PORTS-1:0]           we_i,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] addr_i,
    input  logic [NUM_PORTS*DATA_BITS-1:0] wdata_i,
    input  logic [NUM_PORTS-1:0]           lock_i,
    output logic [NUM_PORTS-1:0]           gnt_o,
    output logic [NUM_PORTS-1:0]           rvalid_o,
    output logic [DATA_BITS-1:0]           rdata_o,
    output logic [IDX_BITS-1:0]            owner_o,
    output logic                           locked_o,
    output logic                           mem_en_o,
    output logic                           mem_we_o,
    output logic [ADDR_BITS-1:0]           mem_addr_o,
    output logic [DATA_BITS-1:0]           mem_wdata_o,
    input  logic [DATA_BITS-1:0]           mem_rdata_i
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e           state_q, state_d;
    logic [IDX_BITS-1:0]   lock_idx_q, lock_idx_d;
    logic [IDX_BITS-1:0]   owner_q, owner_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0]  mem_wdata_q, mem_wdata_d;

    // Read-return pipeline: stage 0 is the address-register stage.
    logic [RD_LATENCY:0]                rd_vld_q;
    logic [RD_LATENCY:0][IDX_BITS-1:0]  rd_idx_q;

    logic                  lock_held;
    logic [NUM_PORTS-1:0]  eligible;
    logic                  accept;
    logic [IDX_BITS-1:0]   win_idx;
    logic [IDX_BITS-1:0]   cand_idx;

    // A lock whose owner has dropped lock_i releases in the same cycle.
    assign lock_held = (state_q == ST_LOCKED) && lock_i[lock_idx_q];

    always_comb begin
        eligible = req_i;
        if (lock_held) begin
            eligible             = '0;
            eligible[lock_idx_q] = req_i[lock_idx_q];
        end
        accept   = 1'b0;
        win_idx  = owner_q;
        cand_idx = '0;
        for (int d = 1; d <= NUM_PORTS; d++) begin
            cand_idx = IDX_BITS'((int'(owner_q) + d) % NUM_PORTS);
            if (!accept && eligible[cand_idx]) begin
                accept  = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        owner_d     = owner_q;
        mem_en_d    = accept;
        mem_we_d    = accept && we_i[win_idx];
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if ((state_q == ST_LOCKED) && !lock_i[lock_idx_q]) begin
            state_d = ST_UNLOCKED;
        end
        if (accept) begin
            owner_d     = win_idx;
            mem_addr_d  = addr_i[int'(win_idx)*ADDR_BITS +: ADDR_BITS];
            mem_wdata_d = wdata_i[int'(win_idx)*DATA_BITS +: DATA_BITS];
            if (lock_i[win_idx]) begin
                state_d    = ST_LOCKED;
                lock_idx_d = win_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            state_q     <= ST_UNLOCKED;
            lock_idx_q  <= '0;
            owner_q     <= IDX_BITS'(NUM_PORTS - 1);
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_vld_q    <= '0;
            rd_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_vld_q    <= {rd_vld_q[RD_LATENCY-1:0], accept && !we_i[win_idx]};
            rd_idx_q    <= {rd_idx_q[RD_LATENCY-1:0], win_idx};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign gnt_o[gi]    = accept && (win_idx == IDX_BITS'(gi));
            assign rvalid_o[gi] = rd_vld_q[RD_LATENCY] &&
                                  (rd_idx_q[RD_LATENCY] == IDX_BITS'(gi));
        end
    endgenerate

    assign rdata_o     = mem_rdata_i;
    assign owner_o     = owner_q;
    assign locked_o    = (state_q == ST_LOCKED);
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: 4 ports, 3-cycle SRAM, scoreboard model checked every
// cycle plus directed literal expectations.
module tb_mem_arbiter_rr;

    localparam int NP = 4;
    localparam int AB = 16;
    localparam int DB = 8;
    localparam int RL = 3;
    localparam int IB = 2;

    logic             clk;
    logic             aclr;
    logic [NP-1:0]    req, we, lock;
    logic [NP*AB-1:0] addr;
    logic [NP*DB-1:0] wdata;
    logic [NP-1:0]    gnt, rvalid;
    logic [DB-1:0]    rdata;
    logic [IB-1:0]    owner;
    logic             locked, mem_en, mem_we;
    logic [AB-1:0]    mem_addr;
    logic [DB-1:0]    mem_wdata, mem_rdata;

    mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .RD_LATENCY(RL)) dut (
        .clk_i(clk), .aclr_i(aclr), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .lock_i(lock), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .owner_o(owner), .locked_o(locked), .mem_en_o(mem_en),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM with RL cycles from registered address to read data.
    logic [DB-1:0] sram [0:65535];
    logic [DB-1:0] rpipe [0:RL-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        rpipe[0] <= sram[mem_addr];
        for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_rdata = rpipe[RL-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard model: owner, lock holder, expected memory command, return schedule.
    int            m_owner, m_holder;
    logic          exp_en, exp_we;
    logic [AB-1:0] exp_addr;
    logic [DB-1:0] exp_wdata;
    int            sched_port [0:63];
    logic [DB-1:0] sched_data [0:63];
    logic [DB-1:0] shadow [0:65535];

    always @(negedge clk) begin : model
        int h, w, slot, c;
        logic [NP-1:0] eg, erv;
        if (aclr) begin
            m_owner   = NP - 1;
            m_holder  = -1;
            exp_en    = 1'b0;
            exp_we    = 1'b0;
            exp_addr  = '0;
            exp_wdata = '0;
            for (int k = 0; k < 64; k++) sched_port[k] = -1;
        end else begin
            h = m_holder;
            if (h >= 0 && !lock[h]) h = -1;
            w = -1;
            for (int d = 1; d <= NP; d++) begin
                c = (m_owner + d) % NP;
                if (w < 0 && req[c] && (h < 0 || c == h)) w = c;
            end
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            cmp("m_gnt", gnt, eg);
            cmp("m_locked", locked, m_holder >= 0);
            cmp("m_owner", owner, m_owner);
            cmp("m_mem_en", mem_en, exp_en);
            cmp("m_mem_we", mem_we, exp_we);
            cmp("m_mem_addr", mem_addr, exp_addr);
            cmp("m_mem_wdata", mem_wdata, exp_wdata);
            slot = cyc % 64;
            erv = '0;
            if (sched_port[slot] >= 0) erv[sched_port[slot]] = 1'b1;
            cmp("m_rvalid", rvalid, erv);
            if (sched_port[slot] >= 0) cmp("m_rdata", rdata, sched_data[slot]);
            sched_port[slot] = -1;
            if (w >= 0) begin
                m_owner   = w;
                exp_en    = 1'b1;
                exp_we    = we[w];
                exp_addr  = addr[w*AB +: AB];
                exp_wdata = wdata[w*DB +: DB];
                if (we[w]) begin
                    shadow[exp_addr] = exp_wdata;
                end else begin
                    slot             = (cyc + 1 + RL) % 64;
                    sched_port[slot] = w;
                    sched_data[slot] = shadow[exp_addr];
                end
                if (lock[w]) h = w;
            end else begin
                exp_en = 1'b0;
                exp_we = 1'b0;
            end
            m_holder = h;
        end
    end

    int         grants [0:NP-1];
    logic [3:0] rv_exp [0:2];
    logic [7:0] rd_exp [0:2];

    initial begin
        aclr = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        for (int i = 0; i < NP; i++) grants[i] = 0;
        repeat (2) @(posedge clk);
        #1 aclr = 1'b0;
        #2;
        cmp("rst_mem_en", mem_en, 0);
        cmp("rst_owner", owner, 3);
        cmp("rst_locked", locked, 0);
        cmp("rst_rvalid", rvalid, 0);

        // All four ports write continuously: order 0,1,2,3,0.
        @(posedge clk); #1;
        req = 4'b1111; we = 4'b1111;
        for (int i = 0; i < NP; i++) begin
            addr[i*AB +: AB]  = 16'h0020 + 16'(i);
            wdata[i*DB +: DB] = 8'h50 + 8'(i);
        end
        for (int k = 0; k < 5; k++) begin
            #2;
            cmp("rr_gnt", gnt, 32'd1 << (k % 4));
            if (k > 0) cmp("rr_mem_en", mem_en, 1);
            if (k < 4) for (int i = 0; i < NP; i++) if (gnt[i]) grants[i]++;
            @(posedge clk); #1;
        end
        req = '0; we = '0;
        for (int i = 0; i < NP; i++) cmp("rr_share", grants[i], 1);

        // Port 1 writes A5 to 0x0010, then port 0 reads it back.
        @(posedge clk); #1;
        req = 4'b0010; we = 4'b0010; addr[1*AB +: AB] = 16'h0010; wdata[1*DB +: DB] = 8'hA5;
        #2 cmp("wr_gnt", gnt, 4'b0010);
        @(posedge clk); #1 req = '0; we = '0;
        @(posedge clk); #1;
        req = 4'b0001; addr[0 +: AB] = 16'h0010;
        #2 cmp("rd_gnt", gnt, 4'b0001);
        @(posedge clk); #1 req = '0;
        repeat (RL) @(posedge clk);
        #3;
        cmp("rd_rvalid", rvalid, 4'b0001);
        cmp("rd_rdata", rdata, 8'hA5);

        // Port 1 locks for five writes while port 0 waits with a read.
        @(posedge clk); #1;
        req = 4'b0011; we = 4'b0010; lock = 4'b0010;
        addr[1*AB +: AB] = 16'h0030; wdata[1*DB +: DB] = 8'h60;
        for (int k = 0; k < 5; k++) begin
            #2;
            cmp("lock_gnt", gnt, 4'b0010);
            if (k > 0) cmp("lock_locked", locked, 1);
            @(posedge clk); #1;
            addr[1*AB +: AB] = 16'h0031 + 16'(k);
        end
        lock = '0;
        #2;
        cmp("unlock_gnt", gnt, 4'b0001);
        cmp("unlock_locked_still", locked, 1);
        @(posedge clk); #1 req = '0; we = '0;
        #2 cmp("unlock_locked", locked, 0);

        // Interleaved reads from ports 2,0,2 return 4,1,4 in issue order.
        repeat (RL + 2) @(posedge clk);
        #1;
        rv_exp[0] = 4'b0100; rv_exp[1] = 4'b0001; rv_exp[2] = 4'b0100;
        rd_exp[0] = 8'h52;   rd_exp[1] = 8'h51;   rd_exp[2] = 8'hA5;
        req = 4'b0100; addr[2*AB +: AB] = 16'h0022;
        #2 cmp("il_gnt_a", gnt, 4'b0100);
        @(posedge clk); #1 req = 4'b0001; addr[0 +: AB] = 16'h0021;
        #2 cmp("il_gnt_b", gnt, 4'b0001);
        @(posedge clk); #1 req = 4'b0100; addr[2*AB +: AB] = 16'h0010;
        #2 cmp("il_gnt_c", gnt, 4'b0100);
        @(posedge clk); #1 req = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #3;
            cmp("il_rvalid", rvalid, rv_exp[k]);
            cmp("il_rdata", rdata, rd_exp[k]);
        end

        // Locked read in flight when reset pulses mid-cycle.
        repeat (RL + 2) @(posedge clk);
        #1;
        req = 4'b1000; we = '0; lock = 4'b1000; addr[3*AB +: AB] = 16'h0010;
        #2 cmp("rst_fl_gnt", gnt, 4'b1000);
        @(posedge clk); #1 req = '0;
        #1;
        cmp("rst_fl_locked_pre", locked, 1);
        cmp("rst_fl_en_pre", mem_en, 1);
        aclr = 1'b1;
        #1;
        cmp("async_mem_en", mem_en, 0);
        cmp("async_mem_addr", mem_addr, 0);
        cmp("async_owner", owner, 3);
        cmp("async_locked", locked, 0);
        cmp("async_rvalid", rvalid, 0);
        @(posedge clk); #1 aclr = 1'b0; lock = '0;
        for (int k = 0; k < RL + 2; k++) begin
            #2;
            cmp("post_rst_rvalid", rvalid, 0);
            cmp("post_rst_mem_en", mem_en, 0);
            @(posedge clk); #1;
        end
        req = 4'b0011;
        #2 cmp("post_rst_gnt", gnt, 4'b0001);
        @(posedge clk); #1 req = '0;
        #2 cmp("post_rst_mem_en_acc", mem_en, 1);

        repeat (RL + 3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
